// File: rtl/coin_accum_pkg.sv
// Shared definitions for the coin accumulator: controller states, coin_sel
// encoding and denomination values in cents.
package coin_accum_pkg;

    // Controller states
    typedef enum logic {
        IDLE   = 1'b0,
        CHANGE = 1'b1
    } state_e;

    // coin_sel encoding
    typedef enum logic [1:0] {
        COIN_5   = 2'd0,
        COIN_10  = 2'd1,
        COIN_25  = 2'd2,
        COIN_100 = 2'd3
    } coin_sel_e;

    // Denomination values in cents
    localparam int unsigned VAL_5   = 5;
    localparam int unsigned VAL_10  = 10;
    localparam int unsigned VAL_25  = 25;
    localparam int unsigned VAL_100 = 100;

endpackage : coin_accum_pkg

// File: rtl/coin_accum_coin_value_dec.sv
// coin_value_dec: maps a coin_sel code to its value in cents.
// Ports:
//   coin_sel     - 2-bit denomination code
//   coin_value_c - WIDTH-bit coin value (combinational)
module coin_value_dec
    import coin_accum_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [1:0]       coin_sel,
    output logic [WIDTH-1:0] coin_value_c
);

    always_comb begin
        coin_value_c = '0;
        case (coin_sel_e'(coin_sel))
            COIN_5:   coin_value_c = WIDTH'(VAL_5);
            COIN_10:  coin_value_c = WIDTH'(VAL_10);
            COIN_25:  coin_value_c = WIDTH'(VAL_25);
            COIN_100: coin_value_c = WIDTH'(VAL_100);
            default:  coin_value_c = '0;
        endcase
    end

endmodule : coin_value_dec

// File: rtl/coin_accum.sv
// coin_accum: vending credit accumulator. Accepts coins up to MAX_CREDIT,
// handles purchase and refund requests, and holds change for a payout
// handshake.
// Ports:
//   clk, rst              - clock, async active-high reset
//   coin_valid, coin_sel  - coin presented and its denomination
//   vend_req, price       - purchase request and item price
//   refund_req            - return all credit
//   change_ack            - payout took change_amt
//   credit                - accumulated credit
//   coin_reject           - coin not accepted (pulse)
//   vend_ok, vend_deny    - purchase result (pulses)
//   change_valid          - change_amt waiting for change_ack
//   change_amt            - amount to pay out
//   busy                  - controller not in IDLE
module coin_accum
    import coin_accum_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_CREDIT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_valid,
    input  logic [1:0]       coin_sel,
    input  logic             vend_req,
    input  logic [WIDTH-1:0] price,
    input  logic             refund_req,
    input  logic             change_ack,
    output logic [WIDTH-1:0] credit,
    output logic             coin_reject,
    output logic             vend_ok,
    output logic             vend_deny,
    output logic             change_valid,
    output logic [WIDTH-1:0] change_amt,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] credit_q, credit_d;
    logic [WIDTH-1:0] change_amt_q, change_amt_d;
    logic             change_valid_q, change_valid_d;
    logic             coin_reject_q, coin_reject_d;
    logic             vend_ok_q, vend_ok_d;
    logic             vend_deny_q, vend_deny_d;

    logic [WIDTH-1:0] coin_value_c;
    logic [WIDTH:0]   coin_sum_c;
    logic [WIDTH-1:0] remainder_c;
    logic             refund_act_c;

    coin_value_dec #(.WIDTH(WIDTH)) u_dec (
        .coin_sel     (coin_sel),
        .coin_value_c (coin_value_c)
    );

    // One extra bit so an over-limit sum never wraps before the compare
    assign coin_sum_c   = {1'b0, credit_q} + {1'b0, coin_value_c};
    assign remainder_c  = credit_q - price;
    // A refund with nothing to return is treated as absent
    assign refund_act_c = refund_req && (credit_q != '0);

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_amt_d   = change_amt_q;
        change_valid_d = change_valid_q;
        coin_reject_d  = 1'b0;
        vend_ok_d      = 1'b0;
        vend_deny_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (refund_act_c) begin
                    state_d        = CHANGE;
                    change_amt_d   = credit_q;
                    change_valid_d = 1'b1;
                    coin_reject_d  = coin_valid;
                end else if (vend_req) begin
                    coin_reject_d = coin_valid;
                    if (credit_q >= price) begin
                        vend_ok_d = 1'b1;
                        credit_d  = remainder_c;
                        if (remainder_c != '0) begin
                            state_d        = CHANGE;
                            change_amt_d   = remainder_c;
                            change_valid_d = 1'b1;
                        end
                    end else begin
                        vend_deny_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_sum_c <= (WIDTH+1)'(MAX_CREDIT)) begin
                        credit_d = coin_sum_c[WIDTH-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_ack) begin
                    state_d        = IDLE;
                    credit_d       = '0;
                    change_amt_d   = '0;
                    change_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            change_amt_q   <= '0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            vend_ok_q      <= 1'b0;
            vend_deny_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_amt_q   <= change_amt_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            vend_ok_q      <= vend_ok_d;
            vend_deny_q    <= vend_deny_d;
        end
    end

    assign credit       = credit_q;
    assign change_amt   = change_amt_q;
    assign change_valid = change_valid_q;
    assign coin_reject  = coin_reject_q;
    assign vend_ok      = vend_ok_q;
    assign vend_deny    = vend_deny_q;
    assign busy         = (state_q == CHANGE);

endmodule : coin_accum

// File: tb/tb_coin_accum.sv
// Directed, table-driven bench for coin_accum with hand-computed expectations.
module tb_coin_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       vend_req;
    logic [7:0] price;
    logic       refund_req;
    logic       change_ack;
    logic [7:0] credit;
    logic       coin_reject;
    logic       vend_ok;
    logic       vend_deny;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic       cv;
        logic [1:0] sel;
        logic       vr;
        logic [7:0] pr;
        logic       rr;
        logic       ack;
        logic [7:0] e_credit;
        logic       e_rej;
        logic       e_ok;
        logic       e_deny;
        logic       e_cvld;
        logic [7:0] e_amt;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    coin_accum #(.WIDTH(8), .MAX_CREDIT(200)) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_sel     (coin_sel),
        .vend_req     (vend_req),
        .price        (price),
        .refund_req   (refund_req),
        .change_ack   (change_ack),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .vend_ok      (vend_ok),
        .vend_deny    (vend_deny),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input int credit_e, input int rej_e,
                           input int ok_e, input int deny_e, input int cvld_e,
                           input int amt_e, input int busy_e);
        chk({tag, " credit"},       int'(credit),       credit_e);
        chk({tag, " coin_reject"},  int'(coin_reject),  rej_e);
        chk({tag, " vend_ok"},      int'(vend_ok),      ok_e);
        chk({tag, " vend_deny"},    int'(vend_deny),    deny_e);
        chk({tag, " change_valid"}, int'(change_valid), cvld_e);
        chk({tag, " change_amt"},   int'(change_amt),   amt_e);
        chk({tag, " busy"},         int'(busy),         busy_e);
    endtask

    task automatic idle_inputs();
        coin_valid = 1'b0; coin_sel = 2'd0; vend_req = 1'b0; price = 8'd0;
        refund_req = 1'b0; change_ack = 1'b0;
    endtask

    // Drive inputs, take one edge, check shortly after it
    task automatic step(input logic cv, input logic [1:0] sel, input logic vr,
                        input logic [7:0] pr, input logic rr, input logic ack);
        coin_valid = cv; coin_sel = sel; vend_req = vr; price = pr;
        refund_req = rr; change_ack = ack;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        //          cv  sel  vr  pr   rr ack  credit rej ok deny cvld amt busy
        vecs.push_back('{1, 2'd2, 0, 8'd0,   0, 0, 8'd25,  0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd2, 0, 8'd0,   0, 0, 8'd50,  0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd3, 0, 8'd0,   0, 0, 8'd150, 0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd3, 0, 8'd0,   0, 0, 8'd150, 1, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{0, 2'd0, 1, 8'd120, 0, 0, 8'd30,  0, 1, 0, 1, 8'd30, 1});
        vecs.push_back('{0, 2'd0, 0, 8'd0,   0, 0, 8'd30,  0, 0, 0, 1, 8'd30, 1});
        vecs.push_back('{1, 2'd0, 0, 8'd0,   0, 0, 8'd30,  1, 0, 0, 1, 8'd30, 1});
        vecs.push_back('{0, 2'd0, 0, 8'd0,   0, 0, 8'd30,  0, 0, 0, 1, 8'd30, 1});
        vecs.push_back('{0, 2'd0, 0, 8'd0,   0, 1, 8'd0,   0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd1, 0, 8'd0,   0, 0, 8'd10,  0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd1, 0, 8'd0,   0, 0, 8'd20,  0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd0, 1, 8'd50,  0, 0, 8'd20,  1, 0, 1, 0, 8'd0,  0});
        vecs.push_back('{0, 2'd0, 1, 8'd50,  0, 0, 8'd20,  0, 0, 1, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd0, 0, 8'd0,   0, 0, 8'd25,  0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd2, 0, 8'd0,   0, 0, 8'd50,  0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd2, 0, 8'd0,   0, 0, 8'd75,  0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{0, 2'd0, 1, 8'd10,  1, 0, 8'd75,  0, 0, 0, 1, 8'd75, 1});
        vecs.push_back('{0, 2'd0, 1, 8'd10,  1, 0, 8'd75,  0, 0, 0, 1, 8'd75, 1});
        vecs.push_back('{0, 2'd0, 0, 8'd0,   0, 1, 8'd0,   0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{0, 2'd0, 0, 8'd0,   0, 1, 8'd0,   0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{0, 2'd0, 0, 8'd0,   1, 0, 8'd0,   0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{0, 2'd0, 1, 8'd0,   0, 0, 8'd0,   0, 1, 0, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd3, 0, 8'd0,   0, 0, 8'd100, 0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd3, 0, 8'd0,   0, 0, 8'd200, 0, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{1, 2'd0, 0, 8'd0,   0, 0, 8'd200, 1, 0, 0, 0, 8'd0,  0});
        vecs.push_back('{0, 2'd0, 1, 8'd200, 0, 0, 8'd0,   0, 1, 0, 0, 8'd0,  0});

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].cv, vecs[i].sel, vecs[i].vr, vecs[i].pr,
                 vecs[i].rr, vecs[i].ack);
            chk_all($sformatf("vec%0d", i), int'(vecs[i].e_credit),
                    int'(vecs[i].e_rej), int'(vecs[i].e_ok),
                    int'(vecs[i].e_deny), int'(vecs[i].e_cvld),
                    int'(vecs[i].e_amt), int'(vecs[i].e_busy));
        end

        // Async reset in the middle of a pending payout
        step(1'b1, 2'd3, 1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b0, 8'd0, 1'b0, 1'b0);
        chk("pre_vend credit", int'(credit), 150);
        step(1'b0, 2'd0, 1'b1, 8'd120, 1'b0, 1'b0);
        chk_all("mid_change", 30, 0, 1, 0, 1, 30, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        step(1'b1, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        chk_all("post_rst_coin", 5, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_coin_accum

// File: doc/coin_accum.md
COIN_ACCUM -- requirements
Module: coin_accum

Interface
REQ-001 Parameter WIDTH, default 8: credit/price/change width in bits.
REQ-002 Parameter MAX_CREDIT, default 200: credit ceiling in cents; must be at most 2**WIDTH-1.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 coin_valid  input  1  one-cycle pulse: a coin is presented.
REQ-006 coin_sel  input  2  denomination: 0=5, 1=10, 2=25, 3=100.
REQ-007 vend_req  input  1  one-cycle pulse: purchase request.
REQ-008 price  input  WIDTH  item price; sampled with vend_req.
REQ-009 refund_req  input  1  one-cycle pulse: return all credit.
REQ-010 change_ack  input  1  payout mechanism has taken change_amt.
REQ-011 credit  output  WIDTH  registered accumulated credit.
REQ-012 coin_reject  output  1  one-cycle pulse: coin not accepted.
REQ-013 vend_ok  output  1  one-cycle pulse: purchase accepted.
REQ-014 vend_deny  output  1  one-cycle pulse: insufficient credit.
REQ-015 change_valid  output  1  change_amt is valid and awaiting change_ack.
REQ-016 change_amt  output  WIDTH  amount to pay out.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The block SHALL implement the states IDLE and CHANGE; all outputs SHALL be registered, so every response appears on the clock edge after its request.
REQ-019 IDLE priority, highest first, SHALL be refund_req, then vend_req, then coin_valid; in that cycle a lower-priority coin_valid SHALL produce coin_reject.
REQ-020 IDLE, refund_req, credit>0: enter CHANGE with change_amt=credit; refund_req with credit=0 SHALL be ignored.
REQ-021 IDLE, vend_req, credit>=price: credit<=credit-price and vend_ok pulses.
REQ-022 If that remainder is nonzero, the block SHALL enter CHANGE with change_amt=remainder; otherwise it SHALL stay in IDLE.
REQ-023 IDLE, vend_req, credit<price: vend_deny pulses; credit and state unchanged.
REQ-024 IDLE, coin_valid: if credit+value<=MAX_CREDIT, add value; otherwise pulse coin_reject with credit unchanged (no wrap-around, no saturation). The sum SHALL be computed at WIDTH+1 bits.
REQ-025 In CHANGE, change_valid SHALL be high and change_amt stable until change_ack is sampled high.
REQ-026 On that change_ack edge: credit<=0, change_valid<=0, next state IDLE.
REQ-027 In CHANGE, coin_valid SHALL pulse coin_reject; vend_req and refund_req SHALL be ignored.
REQ-028 change_ack outside CHANGE SHALL be ignored.
REQ-029 Only one of vend_ok, vend_deny, coin_reject SHALL assert per cycle, except that coin_reject may accompany vend_ok or vend_deny under REQ-019.

Reset
REQ-030 rst high SHALL immediately force state=IDLE, credit=0, change_amt=0, and every pulse output and change_valid=0, regardless of clk.
REQ-031 Reset during CHANGE SHALL discard pending change with no payout.
REQ-032 The first accepted coin after rst deasserts SHALL be sampled on the first rising edge.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE, CHANGE), the coin_sel encoding, and the denomination value constants 5/10/25/100.
REQ-034 Coin decoding SHALL be a sub-module, coin_value_dec: combinational mapping from coin_sel to a WIDTH-bit value.
REQ-035 The credit register SHALL be the only arithmetic state; no additional credit counters are permitted.

Verification
REQ-036 Coins 25, 25, 100 (sel 2, 2, 3) from reset -> credit 25, 50, 150 on successive edges; no coin_reject.
REQ-037 Credit 150, coin 100 -> coin_reject pulse, credit stays 150.
REQ-038 Credit 150, vend_req with price 120 -> vend_ok, credit 30, change_valid with change_amt 30. With change_ack held low 3 cycles, the outputs hold; ack -> credit 0 and IDLE.
REQ-039 Credit 20, vend_req with price 50 -> vend_deny, credit 20, busy 0. The same cycle with coin_valid -> coin_reject as well.
REQ-040 Credit 75, refund_req together with vend_req -> refund wins, change_amt 75, no vend_ok. A coin during CHANGE is rejected.
REQ-041 Assert rst asynchronously mid-CHANGE (change_amt 30) -> outputs clear before the next clk edge; a subsequent coin sel 0 gives credit 5.
